ram_port_ctrl: RTL
==================

// Module: ram_port_ctrl
// PURPOSE
//  Single-clock client-side controller for one port of the team's dual-port RAM (registered read address,
//  so read data appears one cycle after the address). Accepts burst read/write requests on a valid/ready
//  interface, sequences RAM port signals, returns read data through a 2-entry backpressured response buffer.
//  One instance per RAM port; each runs in that port's clock domain.
// PARAMETERS
//  ADDR_W  4  RAM address width; addresses wrap modulo 2**ADDR_W
//  DATA_W  4  RAM word width
//  LEN_W   4  burst length field width; beats = req_len+1 (1..2**LEN_W)
// PORTS
//  clk          in   1       port clock
//  rst          in   1       synchronous, active-high reset
//  req_valid    in   1       request offered
//  req_ready    out  1       request accepted when valid&ready; high only in IDLE
//  req_we       in   1       1=write burst, 0=read burst
//  req_addr     in   ADDR_W  burst start address
//  req_len      in   LEN_W   beats minus one
//  wdata_valid  in   1       write beat offered
//  wdata_ready  out  1       high only in WR state
//  wdata        in   DATA_W  write beat data
//  wr_done      out  1       one-cycle pulse, cycle after last write beat
//  rsp_valid    out  1       read beat available (buffer head)
//  rsp_ready    in   1       consumer takes beat when valid&ready
//  rsp_data     out  DATA_W  read beat data
//  rsp_last     out  1       marks final beat of a read burst
//  busy         out  1       state!=IDLE or reads in flight or buffer non-empty
//  ram_we       out  1       RAM write enable
//  ram_addr     out  ADDR_W  RAM address
//  ram_din      out  DATA_W  RAM write data
//  ram_dout     in   DATA_W  RAM read data (reflects ram_addr of previous cycle)
// BEHAVIOUR
//  - States IDLE, WR, RD. Regs: cur_addr, beats_left, rd_pend (1 bit + last flag), 2-entry buffer.
//  - Reset: state IDLE, cur_addr=0, beats_left=0, rd_pend=0, buffer empty. Outputs: req_ready=1,
//    wdata_ready=0, wr_done=0, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0, ram_we=0, ram_addr=0.
//  - IDLE: req_ready=1 (rsp buffer may still drain); accept -> cur_addr=req_addr, beats_left=req_len,
//    go WR if req_we else RD. No RAM activity in the accept cycle.
//  - WR: ram_addr=cur_addr, ram_din=wdata, ram_we=wdata_valid (combinational). Each accepted beat:
//    cur_addr+1 (wraps), beats_left-1; last beat -> IDLE, wr_done=1 next cycle. wdata_valid low = stall.
//  - RD: issue when (occupancy + rd_pend - pop_this_cycle) < 2; issue drives ram_addr=cur_addr,
//    sets rd_pend next cycle, advances cur_addr/beats_left. Last issue -> IDLE.
//  - Capture: cycle with rd_pend=1 pushes ram_dout (+last flag) into buffer at that edge.
//    Issue-to-rsp_valid latency = 2 cycles; sustained 1 beat/cycle while rsp_ready=1.
//  - When not issuing, ram_addr holds cur_addr; ram_we=0 outside WR.
//  - Buffer never overflows (credit rule); push and pop in same cycle allowed at any occupancy.
//  - Address wrap: 0xF+1 -> 0x0 for ADDR_W=4; burst continues across wrap.
//  - New request may be accepted while previous read beats drain; ordering preserved by the buffer.
//  - rst mid-burst: burst abandoned, beats already written stay in RAM, in-flight/buffered reads dropped.
//  - Same-address conflict with the other RAM port is not arbitrated here; outside this block's scope.
// STRUCTURE
//  - ram_ctrl_pkg: state enum (IDLE/WR/RD), default width localparams.
//  - Sub-module rsp_fifo2: 2-entry synchronous FIFO {last,data}, push/pop/count, same clk/rst.
// TESTING
//  1. Write burst addr=0x2 len=3 data 1,2,3,4, wdata_valid always high -> ram_we 4 cycles, addr 2..5,
//     wr_done pulse cycle after beat 4; read back same -> rsp_data 1,2,3,4, rsp_last on 4th.
//  2. Read addr=0xE len=3 after writing A,B,C,D at E,F,0,1 -> rsp A,B,C,D, ram_addr E,F,0,1 (wrap).
//  3. Read len=7, rsp_ready held 0 for 5 cycles -> exactly 2 beats buffered, no issue beyond credit,
//     no loss/duplication; release -> remaining 6 beats in order, 1/cycle.
//  4. Write len=2 with wdata_valid gaps (1,0,0,1,1) -> ram_we only on valid cycles, correct addresses.
//  5. rst asserted mid read burst (after 2 beats issued) -> next cycle rsp_valid=0, busy=0,
//     req_ready=1, ram_we=0; following request runs cleanly.
//  6. Back-to-back: read len=1 then immediate write len=0 at same address -> read returns old data,
//     later read returns new data.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM port controller.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry synchronous FIFO holding read response beats {last, data}.
// Ports: clk, rst (sync, active-high), push/push_data, pop (ignored when empty),
//        valid/head (current head entry), count (0..2).
module rsp_fifo2 #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_pop;

  assign do_pop = pop && (cnt_q != 2'd0);

  // Pointer/count update; push and pop may coincide at any occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + 2'(push) - 2'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/ram_port_ctrl.sv
// Client-side burst controller for one port of a dual-port RAM with a registered
// read address (read data arrives one cycle after the address).
// Ports: req_* burst request (valid/ready), wdata_* write beats (valid/ready),
//        wr_done write completion pulse, rsp_* read beats (valid/ready, last),
//        busy activity flag, ram_* RAM port pins. clk, rst (sync, active-high).
module ram_port_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              wr_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  beats_left_q, beats_left_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic              wr_done_q, wr_done_d;

  logic              pop;
  logic [1:0]        fifo_cnt;
  logic [2:0]        in_use;
  logic [DATA_W:0]   fifo_head;

  assign pop = rsp_valid && rsp_ready;

  // Credit: buffered + in-flight beats after this cycle's pop must leave a free slot.
  assign in_use = 3'(fifo_cnt) + 3'(rd_pend_q) - 3'(pop);

  // Next-state and burst bookkeeping.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rd_pend_d    = 1'b0;
    rd_last_d    = 1'b0;
    wr_done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cur_addr_d   = req_addr;
          beats_left_d = req_len;
          state_d      = req_we ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        if (wdata_valid) begin
          cur_addr_d   = cur_addr_q + ADDR_W'(1);
          beats_left_d = beats_left_q - LEN_W'(1);
          if (beats_left_q == '0) begin
            state_d   = ST_IDLE;
            wr_done_d = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (in_use < 3'd2) begin
          rd_pend_d    = 1'b1;
          rd_last_d    = (beats_left_q == '0);
          cur_addr_d   = cur_addr_q + ADDR_W'(1);
          beats_left_d = beats_left_q - LEN_W'(1);
          if (beats_left_q == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rd_pend_q    <= rd_pend_d;
      rd_last_q    <= rd_last_d;
      wr_done_q    <= wr_done_d;
    end
  end

  // The cycle after an issue, ram_dout holds that beat; capture it with its last flag.
  rsp_fifo2 #(.W(DATA_W + 1)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_q),
    .push_data ({rd_last_q, ram_dout}),
    .pop       (pop),
    .valid     (rsp_valid),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  assign rsp_data    = fifo_head[DATA_W-1:0];
  assign rsp_last    = fifo_head[DATA_W];
  assign req_ready   = (state_q == ST_IDLE);
  assign wdata_ready = (state_q == ST_WR);
  assign wr_done     = wr_done_q;
  assign busy        = (state_q != ST_IDLE) || rd_pend_q || (fifo_cnt != 2'd0);

  // Address always follows cur_addr; write strobe passes straight through in WR.
  assign ram_addr = cur_addr_q;
  assign ram_din  = wdata;
  assign ram_we   = (state_q == ST_WR) && wdata_valid;

endmodule
